fft_bf_agu: RTL
===============

Name: fft_bf_agu

Overview:
- Sequencing and address-generation stage that directly feeds the shared radix-2 DIT butterfly (2-cycle initiation interval, free-running phase toggle from reset).
- Runs an in-place N-point FFT over a dual-read/dual-write data RAM, whose contents are already in bit-reversed order.
- Per butterfly, issues two data read addresses and one twiddle ROM address, timed so RAM data lands on a butterfly sample (phase-0) cycle.
- Issues the write-back addresses and write enable aligned to the butterfly outputs.

Parameters:
N_LOG2, 4, log2 of FFT size N (N = 16 default); legal 2..12
RD_LAT, 1, data RAM and twiddle ROM read latency in cycles; legal 1..3
ADDR_W, N_LOG2, data RAM address width (derived)
TW_W, N_LOG2-1, twiddle ROM address width (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  request a transform; sampled only in IDLE
busy  out  1  transform in progress
done  out  1  single-cycle pulse after the final write-back
rd_en  out  1  read strobe for data RAM and twiddle ROM
rd_addr0  out  ADDR_W  address of butterfly top input x0
rd_addr1  out  ADDR_W  address of butterfly bottom input x1
tw_addr  out  TW_W  twiddle index k, for W_N^k
wr_en  out  1  write strobe; butterfly out_x0/out_x1 are valid this cycle
wr_addr0  out  ADDR_W  write address for out_x0
wr_addr1  out  ADDR_W  write address for out_x1
stage  out  $clog2(N_LOG2)  current stage index (debug/status)

Behaviour:
- Reset: all outputs 0; FSM in IDLE; internal phase register ph = 0; write pipeline flushed.
- ph toggles every cycle after reset, mirroring the butterfly phase. The butterfly samples its inputs when ph==0.
- Issue slot: a cycle with ph == RD_LAT[0]. RAM data then arrives on a butterfly phase-0 cycle.
- FSM states:
  - IDLE: on start=1, go to ARM. start is ignored in all other states.
  - ARM: wait for the first issue slot, then go to RUN. busy=1 from ARM onward.
  - RUN: issue one butterfly per slot (every 2 cycles), b = 0..N/2-1. After b = N/2-1, go to DRAIN.
  - DRAIN: the next stage's first issue is the first issue slot at or after last_issue + RD_LAT + 3. This guarantees read-after-write across stages. Then RUN with stage+1 if stage < N_LOG2-1; otherwise wait for the last wr_en, then go to DONE.
  - DONE: done=1 and busy=1 for one cycle, then IDLE.
- Address arithmetic for stage s and butterfly b:
  - span = 1<<s; grp = b>>s; pos = b & (span-1)
  - rd_addr0 = (grp<<(s+1)) | pos
  - rd_addr1 = rd_addr0 + span
  - tw_addr = pos << (N_LOG2-1-s)
- rd_en=1 only in issue cycles; addresses hold their last value otherwise.
- Write alignment: wr_en/wr_addr0/wr_addr1 are rd_en/rd_addr0/rd_addr1 delayed by exactly RD_LAT+2 cycles. This matches the butterfly's 2-cycle input-to-output latency.
- rst asserted mid-transform: immediate abort; pending writes are discarded and wr_en is 0 from the next cycle; no done pulse.
- start held high through DONE: starts a new transform from IDLE on the following cycle.

Decomposition:
- Shared package fft_pkg holds:
  - N_LOG2 default and width constants ADDR_W, TW_W
  - state enum {IDLE, ARM, RUN, DRAIN, DONE}
  - pure function bf_addr(s, b) returning {addr0, addr1, tw}
- One natural sub-module, fft_delay_line: a parameterised-depth, parameterised-width shift register with synchronous clear. It is instantiated once for {en, addr0, addr1} with depth RD_LAT+2.

Test Plan:
- N_LOG2=4, RD_LAT=1, start 1 cycle after reset release -> first rd_en when ph==1; stage 0 issues (0,1,tw0), (2,3,tw0), ... (14,15,tw0) at 2-cycle spacing.
- Same config, stage 1 b=1 -> rd_addr0=1, rd_addr1=3, tw_addr=4; stage 3 b=5 -> rd_addr0=5, rd_addr1=13, tw_addr=5.
- Every rd_en at cycle c -> wr_en at c+3 with identical addresses. Stage-1 first issue is exactly 4 cycles after the stage-0 last issue; no read of an address precedes its pending write.
- Full-run timing -> last issue at first_issue+68, last wr_en at +71, done pulse at +72, busy falls at +73. Exactly 32 rd_en and 32 wr_en pulses.
- rst pulsed mid stage 2 -> wr_en=0 from the next cycle; all outputs 0; no done. A new start afterwards reproduces the full sequence.
- RD_LAT=2 -> issue slots at ph==0; wr_en lags rd_en by 4; inter-stage gap of 6 cycles; start pulses while busy are ignored.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Brief    : Shared state encoding and butterfly address helper for the FFT AGU.
// Revision : 1.0
// ============================================================================
package fft_pkg;

    localparam int N_LOG2_DEF = 4;
    localparam int ADDR_W     = N_LOG2_DEF;
    localparam int TW_W       = N_LOG2_DEF - 1;
    localparam int MAX_AW     = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Fields are sized for the largest legal transform; callers keep the low bits.
    typedef struct packed {
        logic [MAX_AW-1:0] addr0;
        logic [MAX_AW-1:0] addr1;
        logic [MAX_AW-1:0] tw;
    } bf_addr_t;

    function automatic bf_addr_t bf_addr(input int n_log2, input int s, input int b);
        int       span;
        int       grp;
        int       pos;
        int       a0;
        int       a1;
        int       tw;
        bf_addr_t r;
        span    = 1 << s;
        grp     = b >> s;
        pos     = b & (span - 1);
        a0      = (grp << (s + 1)) | pos;
        a1      = a0 + span;
        tw      = pos << (n_log2 - 1 - s);
        r.addr0 = a0[MAX_AW-1:0];
        r.addr1 = a1[MAX_AW-1:0];
        r.tw    = tw[MAX_AW-1:0];
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : fft_delay_line
// Brief    : Fixed-depth shift register with synchronous clear.
// Revision : 1.0
// ============================================================================
module fft_delay_line #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_sr [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_sr[i] <= '0;
            end
        end else begin
            r_sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign q = r_sr[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/fft_bf_agu.sv
`default_nettype none
// ============================================================================
// Module   : fft_bf_agu
// Brief    : Butterfly sequencer and read/twiddle/write address generator.
// Revision : 1.0
// ============================================================================
module fft_bf_agu #(
    parameter int N_LOG2 = fft_pkg::N_LOG2_DEF,
    parameter int RD_LAT = 1,
    parameter int ADDR_W = N_LOG2,
    parameter int TW_W   = N_LOG2 - 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      rd_en,
    output logic [ADDR_W-1:0]         rd_addr0,
    output logic [ADDR_W-1:0]         rd_addr1,
    output logic [TW_W-1:0]           tw_addr,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr0,
    output logic [ADDR_W-1:0]         wr_addr1,
    output logic [$clog2(N_LOG2)-1:0] stage
);

    import fft_pkg::*;

    localparam int              c_SW      = $clog2(N_LOG2);
    localparam int              c_BW      = N_LOG2 - 1;
    localparam int              c_CW      = 3;
    localparam int              c_DW      = 1 + 2 * ADDR_W;
    localparam logic            c_SLOT    = 1'(RD_LAT % 2);
    // Gap between stages is RD_LAT+3 rounded up to keep issues on slot cycles.
    localparam logic [c_CW-1:0] c_GAP_M1  = c_CW'((((RD_LAT + 4) / 2) * 2) - 1);
    localparam logic [c_CW-1:0] c_WR_LAST = c_CW'(RD_LAT + 2);
    localparam logic [c_BW-1:0] c_B_LAST  = '1;
    localparam logic [c_SW-1:0] c_S_LAST  = c_SW'(N_LOG2 - 1);

    state_t            r_state;
    state_t            w_state_nx;
    logic              r_ph;
    logic [c_BW-1:0]   r_b;
    logic [c_BW-1:0]   w_b_nx;
    logic [c_BW-1:0]   w_iss_b;
    logic [c_SW-1:0]   r_stage;
    logic [c_SW-1:0]   w_stage_nx;
    logic [c_SW-1:0]   w_iss_stage;
    logic [c_CW-1:0]   r_cnt;
    logic [c_CW-1:0]   w_cnt_nx;
    logic              w_issue;
    logic              w_slot_nx;
    bf_addr_t          w_bf;
    logic              w_unused_bf;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr0;
    logic [ADDR_W-1:0] r_rd_addr1;
    logic [TW_W-1:0]   r_tw;
    logic [c_DW-1:0]   w_wr_q;

    // Outputs are registered, so an issue decided now appears on the next (slot) cycle.
    always_comb begin
        w_state_nx  = r_state;
        w_b_nx      = r_b;
        w_stage_nx  = r_stage;
        w_cnt_nx    = r_cnt;
        w_issue     = 1'b0;
        w_iss_b     = r_b;
        w_iss_stage = r_stage;
        w_slot_nx   = (r_ph != c_SLOT);
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nx = ARM;
                    w_b_nx     = '0;
                    w_stage_nx = '0;
                end
            end
            ARM, RUN: begin
                if (w_slot_nx) begin
                    w_issue = 1'b1;
                    if (r_b == c_B_LAST) begin
                        w_state_nx = DRAIN;
                        w_cnt_nx   = '0;
                    end else begin
                        w_state_nx = RUN;
                        w_b_nx     = r_b + 1'b1;
                    end
                end
            end
            DRAIN: begin
                w_cnt_nx = r_cnt + 1'b1;
                if (r_stage != c_S_LAST) begin
                    if (r_cnt == c_GAP_M1) begin
                        w_issue     = 1'b1;
                        w_iss_stage = r_stage + 1'b1;
                        w_iss_b     = '0;
                        w_stage_nx  = r_stage + 1'b1;
                        w_b_nx      = c_BW'(1);
                        w_state_nx  = RUN;
                    end
                end else if (r_cnt == c_WR_LAST) begin
                    w_state_nx = DONE;
                end
            end
            DONE: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
        w_bf = bf_addr(N_LOG2, int'(w_iss_stage), int'(w_iss_b));
    end

    assign w_unused_bf = ^w_bf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ph       <= 1'b0;
            r_b        <= '0;
            r_stage    <= '0;
            r_cnt      <= '0;
            r_rd_en    <= 1'b0;
            r_rd_addr0 <= '0;
            r_rd_addr1 <= '0;
            r_tw       <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ph    <= ~r_ph;
            r_b     <= w_b_nx;
            r_stage <= w_stage_nx;
            r_cnt   <= w_cnt_nx;
            r_rd_en <= w_issue;
            if (w_issue) begin
                r_rd_addr0 <= w_bf.addr0[ADDR_W-1:0];
                r_rd_addr1 <= w_bf.addr1[ADDR_W-1:0];
                r_tw       <= w_bf.tw[TW_W-1:0];
            end
        end
    end

    // RAM read latency plus the butterfly's two-cycle pipeline.
    fft_delay_line #(
        .DEPTH (RD_LAT + 2),
        .WIDTH (c_DW)
    ) u_wr_dly (
        .clk (clk),
        .rst (rst),
        .d   ({r_rd_en, r_rd_addr0, r_rd_addr1}),
        .q   (w_wr_q)
    );

    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign rd_en    = r_rd_en;
    assign rd_addr0 = r_rd_addr0;
    assign rd_addr1 = r_rd_addr1;
    assign tw_addr  = r_tw;
    assign stage    = r_stage;
    assign wr_en    = w_wr_q[c_DW-1];
    assign wr_addr0 = w_wr_q[2*ADDR_W-1:ADDR_W];
    assign wr_addr1 = w_wr_q[ADDR_W-1:0];

endmodule
`default_nettype wire
